div_iter: RTL and testbench

Iterative 32-bit signed/unsigned divider for the execute stage of the five-stage MIPS core. It is the source of the `stall_divE` request consumed by the hazard unit. It raises that stall while a DIV/DIVU occupies E, and holds the 64-bit {HI, LO} result for the pipeline once done. An exception flush aborts it at any point.

---
 rtl/div_iter_pkg.sv | 19 +
 rtl/div_iter_if.sv | 26 ++
 rtl/div_iter_step.sv | 18 +
 rtl/div_iter.sv | 86 ++++++++
 tb/tb_div_iter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
// Also holds a small helper for the operand magnitudes.
package div_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Magnitude of v when treated as signed; unsigned operands pass through.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Execute-stage <-> divider signal bundle.
// The stage holds div_start (with its operands) for as long as the DIV/DIVU sits in E.
// stall_div is the divider's stall request back to the hazard unit.
// The stage may drop div_start in the cycle after ready is seen with e_hold low.
// annul withdraws the request in any cycle.
interface div_iter_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        e_hold;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  modport master (
    output div_start, div_signed, opdata1, opdata2, annul, e_hold,
    input  stall_div, ready, result
  );

  modport slave (
    input  div_start, div_signed, opdata1, opdata2, annul, e_hold,
    output stall_div, ready, result
  );
endinterface

// File: rtl/div_iter_step.sv
// One restoring-division step on the 65-bit {remainder, quotient} register.
// The register is shifted left, then the divisor is trial-subtracted from bits [64:32].
module div_step (
  input  logic [64:0] rem_in,
  input  logic [31:0] divisor,
  output logic [64:0] rem_out
);
  logic [64:0] shifted;
  logic [33:0] trial;

  always_comb begin
    shifted = rem_in << 1;
    trial   = {1'b0, shifted[64:32]} - {2'b00, divisor};
    // Bit 33 set means the trial subtraction borrowed: restore.
    if (trial[33]) rem_out = shifted;
    else           rem_out = {trial[32:0], shifted[31:1], 1'b1};
  end
endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned 32-bit divider for the E stage.
// Produces stall_div for the hazard unit and holds {HI=remainder, LO=quotient}.
module div_iter
  import div_iter_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  div_iter_if.slave      bus,
  output div_state_t     dbg_state
);
  div_state_t  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [64:0] rq_q;
  logic [31:0] divisor_q;
  logic        q_neg_q, r_neg_q;
  logic [63:0] result_q;

  logic        start_ok, last_step;
  logic [64:0] step_out;
  logic [31:0] q_fix, r_fix;

  div_step u_step (
    .rem_in  (rq_q),
    .divisor (divisor_q),
    .rem_out (step_out)
  );

  assign start_ok  = bus.div_start & ~bus.annul;
  assign last_step = (cnt_q == 5'(DIV_ITERS - 1));
  // Sign correction on the final step output; -MIN/-1 wraps back to MIN.
  assign q_fix = q_neg_q ? (32'd0 - step_out[31:0])  : step_out[31:0];
  assign r_fix = r_neg_q ? (32'd0 - step_out[63:32]) : step_out[63:32];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = (bus.opdata2 != 32'd0) ? BUSY : DONE;
      BUSY: if (last_step) state_d = DONE;
      DONE: if (!bus.e_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.annul) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rq_q      <= 65'd0;
      divisor_q <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            if (bus.opdata2 != 32'd0) begin
              rq_q      <= {33'd0, abs_if(bus.opdata1, bus.div_signed)};
              divisor_q <= abs_if(bus.opdata2, bus.div_signed);
              q_neg_q   <= bus.div_signed & (bus.opdata1[31] ^ bus.opdata2[31]);
              r_neg_q   <= bus.div_signed & bus.opdata1[31];
              cnt_q     <= 5'd0;
            end else begin
              result_q <= {bus.opdata1, DIV_ZERO_QUOT};
            end
          end
        end
        BUSY: begin
          if (!bus.annul) begin
            rq_q  <= step_out;
            cnt_q <= cnt_q + 5'd1;
            if (last_step) result_q <= {r_fix, q_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_div = start_ok & (state_q != DONE);
  assign bus.ready     = (state_q == DONE);
  assign bus.result    = result_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table, random vectors, and
// hand-written annul / hold / reset sequences, with an expected-result queue.
module tb_div_iter;
  import div_iter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_iter_if bus ();
  div_state_t dbg_state;

  div_iter dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built from plain arithmetic on wide signed values.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; that cycle is cycle 0 of the request.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int hold, input string name);
    int stalls = 0;
    int cyc = 0;
    int exp_lat;
    logic [63:0] e;
    exp_lat = (b == 32'd0) ? 1 : 33;
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.e_hold     = (hold > 0);
    exp_q.push_back(exp);
    #1;
    while (cyc < 60 && !bus.ready) begin
      if (bus.stall_div) stalls++;
      cyc++;
      @(negedge clk);
      #1;
      // Operands must be ignored once the request is accepted.
      if (cyc == 1 && !bus.ready) begin
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.div_signed = ~sgn;
      end
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ready within %0d cycles", name, cyc);
      void'(exp_q.pop_front());
      bus.div_start = 1'b0;
      bus.e_hold = 1'b0;
      return;
    end
    chk({name, " stalls"}, 64'(stalls), 64'(exp_lat));
    chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({name, " stall_at_ready"}, 64'(bus.stall_div), 64'd0);
    e = exp_q.pop_front();
    chk({name, " result"}, bus.result, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == hold - 1) bus.e_hold = 1'b0;
      @(negedge clk);
      chk({name, " hold_ready"}, 64'(bus.ready), 64'd1);
      chk({name, " hold_result"}, bus.result, e);
    end
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    @(negedge clk);
    chk({name, " back_idle"}, 64'(dbg_state), 64'(IDLE));
    chk({name, " ready_clear"}, 64'(bus.ready), 64'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'd2, 32'd14},                 "divu_100_7"};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},  "div_m7_2"};
    vecs[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000},          "div_ovf"};
    vecs[3]  = '{32'h0000_1234, 32'd0,         1'b0, {32'h0000_1234, 32'hFFFF_FFFF},  "divu_zero"};
    vecs[4]  = '{32'd9,         32'd3,         1'b0, {32'd0, 32'd3},                  "divu_9_3"};
    vecs[5]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, {32'd0, 32'hFFFF_FFFF},          "divu_max_1"};
    vecs[6]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD},          "div_7_m2"};
    vecs[7]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFF, 32'd3},          "div_m7_m2"};
    vecs[8]  = '{32'd5,         32'd10,        1'b0, {32'd5, 32'd0},                  "divu_5_10"};
    vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'd0, 32'd1},                  "divu_max_max"};
    vecs[10] = '{32'hFFFF_FFFB, 32'd0,         1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF},  "div_zero_neg"};

    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.opdata1    = 32'd0;
    bus.opdata2    = 32'd0;
    bus.annul      = 1'b0;
    bus.e_hold     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_stall", 64'(bus.stall_div), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, 0, vecs[i].name);

    // Random vectors against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, model(ra, rb, rs), 0, "rand");
    end

    // Annul in cycle 10, then 9/3 issued in cycle 12
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    repeat (10) @(negedge clk);
    chk("annul_busy", 64'(dbg_state), 64'(BUSY));
    bus.annul = 1'b1;
    #1;
    chk("annul_stall_drop", 64'(bus.stall_div), 64'd0);
    @(negedge clk);
    bus.annul = 1'b0;
    bus.div_start = 1'b0;
    #1;
    chk("annul_idle", 64'(dbg_state), 64'(IDLE));
    chk("annul_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0, "after_annul");

    // e_hold for 4 cycles in DONE
    do_div(32'd50, 32'hFFFF_FFFA, 1'b1, model(32'd50, 32'hFFFF_FFFA, 1'b1), 4, "hold");

    // Reset during BUSY cycle 20
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    repeat (20) @(negedge clk);
    chk("rst_mid_busy", 64'(dbg_state), 64'(BUSY));
    resetn = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_mid_ready", 64'(bus.ready), 64'd0);
    chk("rst_mid_result", bus.result, 64'd0);
    chk("rst_mid_stall", 64'(bus.stall_div), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, "after_reset");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
